// File: rtl/frame_scan_streamer.sv
// Raster-scan reader: walks (x,y) over the pixel memory, maps 2-bit codes to
// grayscale and streams one pixel per beat with sof/eol markers under valid/ready.
module frame_scan_streamer #(
  parameter int frame_width  = 640,
  parameter int frame_height = 480
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        continuous,
  output logic [31:0] width,
  output logic [31:0] height,
  input  logic [1:0]  pix_value,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [7:0]  m_data,
  output logic        m_sof,
  output logic        m_eol,
  output logic        busy,
  output logic        frame_done,
  output logic [15:0] frame_count
);

  localparam int XW = (frame_width  > 1) ? $clog2(frame_width)  : 1;
  localparam int YW = (frame_height > 1) ? $clog2(frame_height) : 1;

  typedef enum logic [1:0] {IDLE, SCAN, FLUSH} state_t;

  state_t        state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          m_valid_q, m_valid_d;
  logic [7:0]    m_data_q, m_data_d;
  logic          m_sof_q, m_sof_d;
  logic          m_eol_q, m_eol_d;
  logic          busy_q, busy_d;
  logic          frame_done_q, frame_done_d;
  logic [15:0]   frame_count_q, frame_count_d;
  logic          load, last_x, last_y;

  assign last_x = (x_q == XW'(frame_width - 1));
  assign last_y = (y_q == YW'(frame_height - 1));
  assign load   = (state_q == SCAN) && (!m_valid_q || m_ready);

  always_comb begin
    state_d       = state_q;
    x_d           = x_q;
    y_d           = y_q;
    m_valid_d     = m_valid_q;
    m_data_d      = m_data_q;
    m_sof_d       = m_sof_q;
    m_eol_d       = m_eol_q;
    frame_done_d  = 1'b0;
    frame_count_d = frame_count_q;
    case (state_q)
      IDLE: begin
        x_d = '0;
        y_d = '0;
        if (start) state_d = SCAN;
      end
      SCAN: begin
        // Counters only move on load, so stalls freeze the memory coordinates too.
        if (load) begin
          m_data_d  = {4{pix_value}};
          m_sof_d   = (x_q == '0) && (y_q == '0);
          m_eol_d   = last_x;
          m_valid_d = 1'b1;
          if (last_x) begin
            x_d = '0;
            if (last_y) begin
              y_d     = '0;
              state_d = FLUSH;
            end else begin
              y_d = y_q + YW'(1);
            end
          end else begin
            x_d = x_q + XW'(1);
          end
        end
      end
      FLUSH: begin
        if (m_ready) begin
          m_valid_d     = 1'b0;
          frame_done_d  = 1'b1;
          frame_count_d = frame_count_q + 16'd1;
          state_d       = continuous ? SCAN : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      x_q           <= '0;
      y_q           <= '0;
      m_valid_q     <= 1'b0;
      m_data_q      <= 8'h00;
      m_sof_q       <= 1'b0;
      m_eol_q       <= 1'b0;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_count_q <= 16'd0;
    end else begin
      state_q       <= state_d;
      x_q           <= x_d;
      y_q           <= y_d;
      m_valid_q     <= m_valid_d;
      m_data_q      <= m_data_d;
      m_sof_q       <= m_sof_d;
      m_eol_q       <= m_eol_d;
      busy_q        <= busy_d;
      frame_done_q  <= frame_done_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign width       = {{(32-XW){1'b0}}, x_q};
  assign height      = {{(32-YW){1'b0}}, y_q};
  assign m_valid     = m_valid_q;
  assign m_data      = m_data_q;
  assign m_sof       = m_sof_q;
  assign m_eol       = m_eol_q;
  assign busy        = busy_q;
  assign frame_done  = frame_done_q;
  assign frame_count = frame_count_q;

endmodule
